dbsao_ctu_scheduler: RTL and testbench
======================================

Name: dbsao_ctu_scheduler

Overview:
- Frame-level sequencer for the deblock/SAO engine.
- Walks CTUs in raster order across a picture.
- Tracks reconstructed-CTU credits from the upstream stage and gates on downstream output-buffer availability.
- Issues one start pulse per CTU to the DB/SAO controller, waits for its done pulse, then advances position and signals frame completion.

Parameters:
- CTU_BITS, 7, width of CTU x/y coordinates and picture dimensions (in CTUs).
- CREDIT_MAX, 4, maximum outstanding reconstructed-CTU credits; credit counter is 3 bits wide.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sys_start_i  in  1  frame start pulse; honoured only in IDLE
- pic_w_ctu_i  in  CTU_BITS  picture width in CTUs; sampled on accepted sys_start_i
- pic_h_ctu_i  in  CTU_BITS  picture height in CTUs; sampled on accepted sys_start_i
- rec_ready_i  in  1  pulse: one more reconstructed CTU available upstream
- out_ready_i  in  1  level: output buffer can accept a CTU
- db_done_i  in  1  pulse from DB/SAO controller: current CTU finished
- db_start_o  out  1  registered one-cycle start pulse to DB/SAO controller
- ctu_x_o  out  CTU_BITS  current CTU column
- ctu_y_o  out  CTU_BITS  current CTU row
- first_col_o / last_col_o / first_row_o / last_row_o  out  1 each  combinational boundary flags from x/y versus latched dimensions
- credit_o  out  3  current credit count
- busy_o  out  1  state != IDLE
- frame_done_o  out  1  one-cycle pulse at end of frame
- err_o  out  1  sticky error: credit overflow, or db_done_i outside RUN; cleared only on accepted sys_start_i or reset

Behaviour:
- Reset values: all outputs 0; state IDLE; latched dimensions 0.
- States: IDLE, WAIT, RUN, NEXT, DONE.
- IDLE:
  - On sys_start_i: latch dimensions, clamping 0 to 1; clear x, y, credit, err_o; go to WAIT.
  - rec_ready_i is ignored in IDLE, including the cycle in which sys_start_i is accepted.
- WAIT:
  - If credit>0 and out_ready_i: go to RUN and decrement credit.
  - db_start_o is high for exactly the first RUN cycle (registered).
  - Otherwise stay in WAIT.
- RUN:
  - x/y are held stable.
  - On db_done_i: go to DONE if x==w-1 and y==h-1, else to NEXT.
  - db_done_i in the same cycle as db_start_o is accepted.
- NEXT (one cycle):
  - If x==w-1: x=0 and y=y+1; else x=x+1.
  - Always go to WAIT.
- DONE (one cycle): frame_done_o=1, then go to IDLE. x/y hold their final values until the next start.
- Minimum latency: sys_start_i at cycle T → WAIT at T+1. Credit arriving at T+1 registers at T+2 → db_start_o at T+3.
- Credit rules:
  - Increment on rec_ready_i in any non-IDLE state.
  - Increment and decrement in the same cycle leave the count unchanged.
  - Increment at CREDIT_MAX with no simultaneous decrement is dropped and sets err_o.
- sys_start_i outside IDLE is ignored (no error).
- db_done_i outside RUN sets err_o; state is unaffected.
- Asynchronous reset mid-frame returns immediately to reset values. No db_start_o is emitted after reset deassertion until a new sys_start_i is accepted.

Decomposition:
- Shared package dbsao_pkg: state encodings (IDLE, WAIT, RUN, NEXT, DONE), CTU_BITS, CREDIT_MAX.
- One natural sub-module: dbsao_credit_cnt (saturating up/down counter with overflow flag).
- Position counter and FSM stay in the top module.

Test Plan:
- 2x2 picture, four rec_ready_i pulses early, out_ready_i=1, db_done_i 10 cycles after each start → four db_start_o at (x,y) = (0,0),(1,0),(0,1),(1,1), flags correct, one frame_done_o, busy_o falls the cycle after.
- out_ready_i=0 for 20 cycles with credit=2 → no db_start_o; start occurs in the cycle after out_ready_i rises, credit_o 2→1.
- Five rec_ready_i pulses with no consumption → credit_o saturates at 4, err_o=1. Then rec_ready_i together with consumption at 4 → credit_o stays 4, err_o unchanged.
- db_done_i pulsed in WAIT → err_o=1, state stays WAIT, x/y unchanged.
- pic_w_ctu_i=0, pic_h_ctu_i=0 with one credit → exactly one CTU processed at (0,0), then frame_done_o.
- rst_n asserted during RUN of CTU (1,0) → all outputs 0 immediately. After release, no db_start_o until a new sys_start_i; the new frame starts at (0,0) with credit 0.

Source files
------------

// File: rtl/dbsao_pkg.sv
// Shared constants and state encoding for the deblock/SAO CTU scheduler.
package dbsao_pkg;

    localparam int CTU_BITS   = 7;
    localparam int CREDIT_MAX = 4;
    localparam int CREDIT_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RUN,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/dbsao_credit_cnt.sv
// Saturating up/down credit counter; overflow strobes when an increment is dropped at the ceiling.
module dbsao_credit_cnt
    import dbsao_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] count,
    output logic                overflow
);

    logic at_max;

    assign at_max   = (count == CREDIT_W'(CREDIT_MAX));
    assign overflow = inc && !dec && at_max;

    // A simultaneous increment and decrement cancel out; the caller never decrements at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + CREDIT_W'(1);
        end else if (dec && !inc) begin
            count <= count - CREDIT_W'(1);
        end
    end

endmodule

// File: rtl/dbsao_ctu_scheduler.sv
// Frame-level sequencer: walks CTUs in raster order, gating each DB/SAO start on
// an upstream credit and downstream buffer space.
module dbsao_ctu_scheduler
    import dbsao_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sys_start_i,
    input  logic [CTU_BITS-1:0] pic_w_ctu_i,
    input  logic [CTU_BITS-1:0] pic_h_ctu_i,
    input  logic                rec_ready_i,
    input  logic                out_ready_i,
    input  logic                db_done_i,
    output logic                db_start_o,
    output logic [CTU_BITS-1:0] ctu_x_o,
    output logic [CTU_BITS-1:0] ctu_y_o,
    output logic                first_col_o,
    output logic                last_col_o,
    output logic                first_row_o,
    output logic                last_row_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                err_o
);

    state_t              state;
    logic [CTU_BITS-1:0] pic_w;
    logic [CTU_BITS-1:0] pic_h;
    logic                start_accept;
    logic                credit_inc;
    logic                credit_dec;
    logic                credit_ovf;
    logic                at_last_col;
    logic                at_last_row;
    logic                dims_valid;

    assign start_accept = (state == IDLE) && sys_start_i;
    assign credit_inc   = rec_ready_i && (state != IDLE);
    assign credit_dec   = (state == WAIT) && (credit_o != '0) && out_ready_i;

    assign at_last_col  = (ctu_x_o == pic_w - CTU_BITS'(1));
    assign at_last_row  = (ctu_y_o == pic_h - CTU_BITS'(1));

    // Latched dimensions are zero only before the first frame, which keeps the flags low out of reset.
    assign dims_valid   = (pic_w != '0) && (pic_h != '0);
    assign first_col_o  = dims_valid && (ctu_x_o == '0);
    assign last_col_o   = dims_valid && at_last_col;
    assign first_row_o  = dims_valid && (ctu_y_o == '0);
    assign last_row_o   = dims_valid && at_last_row;
    assign busy_o       = (state != IDLE);

    dbsao_credit_cnt u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_accept),
        .inc      (credit_inc),
        .dec      (credit_dec),
        .count    (credit_o),
        .overflow (credit_ovf)
    );

    // Error sets are overridden by the clear of an accepted start in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pic_w        <= '0;
            pic_h        <= '0;
            ctu_x_o      <= '0;
            ctu_y_o      <= '0;
            db_start_o   <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            db_start_o   <= 1'b0;
            frame_done_o <= 1'b0;
            if (credit_ovf || (db_done_i && (state != RUN))) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sys_start_i) begin
                        pic_w   <= (pic_w_ctu_i == '0) ? CTU_BITS'(1) : pic_w_ctu_i;
                        pic_h   <= (pic_h_ctu_i == '0) ? CTU_BITS'(1) : pic_h_ctu_i;
                        ctu_x_o <= '0;
                        ctu_y_o <= '0;
                        err_o   <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (credit_dec) begin
                        db_start_o <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (db_done_i) begin
                        if (at_last_col && at_last_row) begin
                            frame_done_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (at_last_col) begin
                        ctu_x_o <= '0;
                        ctu_y_o <= ctu_y_o + CTU_BITS'(1);
                    end else begin
                        ctu_x_o <= ctu_x_o + CTU_BITS'(1);
                    end
                    state <= WAIT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbsao_ctu_scheduler.sv
// Directed self-checking bench for the DB/SAO CTU scheduler.
module tb_dbsao_ctu_scheduler;
    import dbsao_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                sys_start_i;
    logic [CTU_BITS-1:0] pic_w_ctu_i;
    logic [CTU_BITS-1:0] pic_h_ctu_i;
    logic                rec_ready_i;
    logic                out_ready_i;
    logic                db_done_i;
    logic                db_start_o;
    logic [CTU_BITS-1:0] ctu_x_o;
    logic [CTU_BITS-1:0] ctu_y_o;
    logic                first_col_o;
    logic                last_col_o;
    logic                first_row_o;
    logic                last_row_o;
    logic [CREDIT_W-1:0] credit_o;
    logic                busy_o;
    logic                frame_done_o;
    logic                err_o;

    int checks;
    int failures;

    dbsao_ctu_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sys_start_i  (sys_start_i),
        .pic_w_ctu_i  (pic_w_ctu_i),
        .pic_h_ctu_i  (pic_h_ctu_i),
        .rec_ready_i  (rec_ready_i),
        .out_ready_i  (out_ready_i),
        .db_done_i    (db_done_i),
        .db_start_o   (db_start_o),
        .ctu_x_o      (ctu_x_o),
        .ctu_y_o      (ctu_y_o),
        .first_col_o  (first_col_o),
        .last_col_o   (last_col_o),
        .first_row_o  (first_row_o),
        .last_row_o   (last_row_o),
        .credit_o     (credit_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic waitStart(input int limit, output int n);
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!db_start_o && n < limit);
    endtask

    task automatic startFrame(input int w, input int h);
        pic_w_ctu_i = CTU_BITS'(w);
        pic_h_ctu_i = CTU_BITS'(h);
        sys_start_i = 1'b1;
        applyStimulus();
        sys_start_i = 1'b0;
    endtask

    task automatic pulseDone();
        db_done_i = 1'b1;
        applyStimulus();
        db_done_i = 1'b0;
    endtask

    task automatic giveCredits(input int n);
        rec_ready_i = 1'b1;
        repeat (n) applyStimulus();
        rec_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        int ex;
        int ey;
        logic seen;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        sys_start_i = 1'b0;
        pic_w_ctu_i = '0;
        pic_h_ctu_i = '0;
        rec_ready_i = 1'b0;
        out_ready_i = 1'b0;
        db_done_i = 1'b0;
        #12;
        checkOutput("reset_all", 32'({db_start_o, ctu_x_o, ctu_y_o, first_col_o, last_col_o,
                    first_row_o, last_row_o, credit_o, busy_o, frame_done_o, err_o}), 32'd0);
        rst_n = 1'b1;
        applyStimulus();

        // 2x2 frame, four credits banked up front.
        startFrame(2, 2);
        checkOutput("f1_busy", 32'(busy_o), 32'd1);
        checkOutput("f1_credit0", 32'(credit_o), 32'd0);
        giveCredits(4);
        checkOutput("f1_credit4", 32'(credit_o), 32'd4);
        out_ready_i = 1'b1;
        waitStart(20, n);
        checkOutput("f1_lat0", 32'(n), 32'd1);
        for (int k = 0; k < 4; k++) begin
            ex = k % 2;
            ey = k / 2;
            checkOutput("f1_start", 32'(db_start_o), 32'd1);
            checkOutput("f1_x", 32'(ctu_x_o), 32'(ex));
            checkOutput("f1_y", 32'(ctu_y_o), 32'(ey));
            checkOutput("f1_flags", 32'({first_col_o, last_col_o, first_row_o, last_row_o}),
                        32'({ex == 0, ex == 1, ey == 0, ey == 1}));
            checkOutput("f1_credit", 32'(credit_o), 32'(3 - k));
            seen = 1'b0;
            repeat (9) begin
                applyStimulus();
                if (db_start_o) seen = 1'b1;
            end
            checkOutput("f1_single_start", 32'(seen), 32'd0);
            pulseDone();
            if (k < 3) begin
                checkOutput("f1_no_done", 32'(frame_done_o), 32'd0);
                waitStart(20, n);
                checkOutput("f1_lat", 32'(n), 32'd2);
            end
        end
        checkOutput("f1_frame_done", 32'(frame_done_o), 32'd1);
        checkOutput("f1_busy_done", 32'(busy_o), 32'd1);
        applyStimulus();
        checkOutput("f1_done_pulse", 32'(frame_done_o), 32'd0);
        checkOutput("f1_idle", 32'(busy_o), 32'd0);
        checkOutput("f1_hold_xy", 32'({ctu_x_o, ctu_y_o}), 32'({7'd1, 7'd1}));
        checkOutput("f1_err", 32'(err_o), 32'd0);

        // 3x1 frame: back-pressure, then credit saturation.
        out_ready_i = 1'b0;
        startFrame(3, 1);
        giveCredits(2);
        seen = 1'b0;
        repeat (20) begin
            applyStimulus();
            if (db_start_o) seen = 1'b1;
        end
        checkOutput("bp_no_start", 32'(seen), 32'd0);
        checkOutput("bp_credit2", 32'(credit_o), 32'd2);
        out_ready_i = 1'b1;
        applyStimulus();
        checkOutput("bp_start", 32'(db_start_o), 32'd1);
        checkOutput("bp_credit1", 32'(credit_o), 32'd1);
        giveCredits(3);
        checkOutput("sat_credit4", 32'(credit_o), 32'd4);
        checkOutput("sat_no_err", 32'(err_o), 32'd0);
        giveCredits(1);
        checkOutput("sat_hold4", 32'(credit_o), 32'd4);
        checkOutput("sat_err", 32'(err_o), 32'd1);
        pulseDone();
        applyStimulus();
        checkOutput("sat_x1", 32'(ctu_x_o), 32'd1);
        giveCredits(1);
        checkOutput("sat_incdec_start", 32'(db_start_o), 32'd1);
        checkOutput("sat_incdec_credit", 32'(credit_o), 32'd4);
        checkOutput("sat_err_sticky", 32'(err_o), 32'd1);
        pulseDone();
        waitStart(20, n);
        checkOutput("f2_lat", 32'(n), 32'd2);
        checkOutput("f2_x2", 32'(ctu_x_o), 32'd2);
        checkOutput("f2_credit3", 32'(credit_o), 32'd3);
        pulseDone();
        checkOutput("f2_frame_done", 32'(frame_done_o), 32'd1);
        applyStimulus();

        // db_done while waiting, then reset mid-frame at CTU (1,0).
        out_ready_i = 1'b0;
        startFrame(3, 2);
        checkOutput("wd_err_cleared", 32'(err_o), 32'd0);
        checkOutput("wd_credit_cleared", 32'(credit_o), 32'd0);
        pulseDone();
        checkOutput("wd_err", 32'(err_o), 32'd1);
        checkOutput("wd_xy", 32'({ctu_x_o, ctu_y_o}), 32'd0);
        checkOutput("wd_busy", 32'(busy_o), 32'd1);
        giveCredits(1);
        out_ready_i = 1'b1;
        applyStimulus();
        checkOutput("wd_still_wait", 32'(db_start_o), 32'd1);
        db_done_i = 1'b1;
        rec_ready_i = 1'b1;
        applyStimulus();
        db_done_i = 1'b0;
        rec_ready_i = 1'b0;
        waitStart(20, n);
        checkOutput("rs_lat", 32'(n), 32'd2);
        checkOutput("rs_xy", 32'({ctu_x_o, ctu_y_o}), 32'({7'd1, 7'd0}));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rs_all_zero", 32'({db_start_o, ctu_x_o, ctu_y_o, first_col_o, last_col_o,
                    first_row_o, last_row_o, credit_o, busy_o, frame_done_o, err_o}), 32'd0);
        #3;
        rst_n = 1'b1;
        rec_ready_i = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            applyStimulus();
            if (db_start_o || busy_o || credit_o != '0) seen = 1'b1;
        end
        rec_ready_i = 1'b0;
        checkOutput("rs_quiet", 32'(seen), 32'd0);

        // Zero dimensions clamp to a single CTU.
        startFrame(0, 0);
        checkOutput("z_credit0", 32'(credit_o), 32'd0);
        checkOutput("z_flags", 32'({first_col_o, last_col_o, first_row_o, last_row_o}), 32'hf);
        giveCredits(1);
        applyStimulus();
        checkOutput("z_start", 32'(db_start_o), 32'd1);
        checkOutput("z_xy", 32'({ctu_x_o, ctu_y_o}), 32'd0);
        pulseDone();
        checkOutput("z_frame_done", 32'(frame_done_o), 32'd1);
        applyStimulus();
        checkOutput("z_idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
